pipe_hazard_unit: RTL and testbench

PIPE_HAZARD_UNIT -- requirements
Module: pipe_hazard_unit

---
 rtl/pipe_hazard_unit.sv | 134 +++++++++++++
 tb/tb_pipe_hazard_unit.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_unit.sv
// Pipeline hazard unit: tracks the E/M/W producers to choose operand forwarding,
// raise load-use and multi-cycle stalls, and flush on a taken branch.
module pipe_hazard_unit #(
  parameter int DATA_W  = 32,
  parameter int RADDR_W = 5,
  parameter int MUL_LAT = 3
) (
  input  logic               iClk,
  input  logic               iReset,
  input  logic               iIssueValid,
  input  logic [RADDR_W-1:0] iRs,
  input  logic [RADDR_W-1:0] iRt,
  input  logic               iUseRs,
  input  logic               iUseRt,
  input  logic [RADDR_W-1:0] iWaddr,
  input  logic               iRegWrite,
  input  logic               iMemtoReg,
  input  logic               iMulti,
  input  logic               iBranchTaken,
  input  logic [DATA_W-1:0]  iRdataRs,
  input  logic [DATA_W-1:0]  iRdataRt,
  input  logic [DATA_W-1:0]  iAluResM,
  input  logic [DATA_W-1:0]  iResultW,
  output logic [DATA_W-1:0]  oOpA,
  output logic [DATA_W-1:0]  oOpB,
  output logic [1:0]         oFwdA,
  output logic [1:0]         oFwdB,
  output logic               oStallF,
  output logic               oStallD,
  output logic               oFlushD,
  output logic               oFlushE,
  output logic               oBusy
);

  typedef struct packed {
    logic               valid;
    logic [RADDR_W-1:0] waddr;
    logic               regWrite;
    logic               load;
  } StageEntry;

  localparam logic [3:0] mulLoad = 4'(MUL_LAT - 1);

  StageEntry          entE;
  StageEntry          entM;
  logic               wValid;
  logic               wRegWrite;
  logic [RADDR_W-1:0] wWaddr;
  logic [3:0]         busyCnt;

  logic matchEA, matchEB, matchMA, matchMB, matchWA, matchWB;
  logic busy, hazard, branch, enterE;

  function automatic logic srcMatch(input logic useFlag, input logic [RADDR_W-1:0] src,
                                    input logic valid, input logic regWrite,
                                    input logic [RADDR_W-1:0] waddr);
    return useFlag && (src != '0) && valid && regWrite && (src == waddr);
  endfunction

  // Everything is gated by iReset so the outputs are quiet while reset is held,
  // even before the clearing edge has arrived.
  always_comb begin
    matchEA = iReset && srcMatch(iUseRs, iRs, entE.valid, entE.regWrite, entE.waddr);
    matchEB = iReset && srcMatch(iUseRt, iRt, entE.valid, entE.regWrite, entE.waddr);
    matchMA = iReset && srcMatch(iUseRs, iRs, entM.valid, entM.regWrite, entM.waddr);
    matchMB = iReset && srcMatch(iUseRt, iRt, entM.valid, entM.regWrite, entM.waddr);
    matchWA = iReset && srcMatch(iUseRs, iRs, wValid, wRegWrite, wWaddr);
    matchWB = iReset && srcMatch(iUseRt, iRt, wValid, wRegWrite, wWaddr);
    busy    = iReset && (busyCnt != 4'd0);
    hazard  = iIssueValid && (matchEA || matchEB || (entM.load && (matchMA || matchMB)));
    branch  = iReset && iBranchTaken && !busy;
    enterE  = iIssueValid && !hazard && !branch;
  end

  assign oBusy   = busy;
  assign oStallF = busy || (hazard && !branch);
  assign oStallD = busy || (hazard && !branch);
  assign oFlushD = branch;
  assign oFlushE = branch || (hazard && !busy);

  // A load sitting in M has no data yet, so it never wins the forward mux.
  always_comb begin
    oFwdA = 2'b00;
    oOpA  = iRdataRs;
    if (matchMA && !entM.load) begin
      oFwdA = 2'b01;
      oOpA  = iAluResM;
    end else if (matchWA) begin
      oFwdA = 2'b10;
      oOpA  = iResultW;
    end
    oFwdB = 2'b00;
    oOpB  = iRdataRt;
    if (matchMB && !entM.load) begin
      oFwdB = 2'b01;
      oOpB  = iAluResM;
    end else if (matchWB) begin
      oFwdB = 2'b10;
      oOpB  = iResultW;
    end
  end

  // While busy the multi-cycle op parks in E and M receives bubbles.
  always_ff @(posedge iClk) begin
    if (!iReset) begin
      entE      <= '0;
      entM      <= '0;
      wValid    <= 1'b0;
      wWaddr    <= '0;
      wRegWrite <= 1'b0;
      busyCnt   <= 4'd0;
    end else begin
      wValid    <= entM.valid;
      wWaddr    <= entM.waddr;
      wRegWrite <= entM.regWrite;
      if (busy) begin
        entM    <= '0;
        busyCnt <= busyCnt - 4'd1;
      end else begin
        entM <= entE;
        if (enterE) begin
          entE.valid    <= 1'b1;
          entE.waddr    <= iWaddr;
          entE.regWrite <= iRegWrite;
          entE.load     <= iMemtoReg;
          if (iMulti) busyCnt <= mulLoad;
        end else begin
          entE <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_pipe_hazard_unit.sv
// Directed bench for pipe_hazard_unit: forwarding, load-use, multi-cycle busy,
// branch flush and reset behaviour with hand-computed expectations.
module tb_pipe_hazard_unit;

  logic        iClk = 1'b0;
  logic        iReset;
  logic        iIssueValid;
  logic [4:0]  iRs, iRt, iWaddr;
  logic        iUseRs, iUseRt, iRegWrite, iMemtoReg, iMulti, iBranchTaken;
  logic [31:0] iRdataRs, iRdataRt, iAluResM, iResultW;
  logic [31:0] oOpA, oOpB;
  logic [1:0]  oFwdA, oFwdB;
  logic        oStallF, oStallD, oFlushD, oFlushE, oBusy;

  int nChecks = 0;
  int nFails  = 0;

  pipe_hazard_unit #(.DATA_W(32), .RADDR_W(5), .MUL_LAT(3)) dut (
    .iClk(iClk), .iReset(iReset), .iIssueValid(iIssueValid),
    .iRs(iRs), .iRt(iRt), .iUseRs(iUseRs), .iUseRt(iUseRt),
    .iWaddr(iWaddr), .iRegWrite(iRegWrite), .iMemtoReg(iMemtoReg), .iMulti(iMulti),
    .iBranchTaken(iBranchTaken),
    .iRdataRs(iRdataRs), .iRdataRt(iRdataRt), .iAluResM(iAluResM), .iResultW(iResultW),
    .oOpA(oOpA), .oOpB(oOpB), .oFwdA(oFwdA), .oFwdB(oFwdB),
    .oStallF(oStallF), .oStallD(oStallD), .oFlushD(oFlushD), .oFlushE(oFlushE), .oBusy(oBusy)
  );

  always #5 iClk = ~iClk;

  task automatic tick();
    @(posedge iClk);
    #1;
  endtask

  task automatic setIdle();
    iIssueValid = 0; iRs = 0; iRt = 0; iUseRs = 0; iUseRt = 0; iWaddr = 0;
    iRegWrite = 0; iMemtoReg = 0; iMulti = 0; iBranchTaken = 0;
    iRdataRs = 32'hA0A0_0001; iRdataRt = 32'hB0B0_0002;
    iAluResM = 32'h0000_0007; iResultW = 32'hDEAD_BEEF;
  endtask

  task automatic issue(input logic [4:0] rs, input logic useRs, input logic [4:0] rt,
                       input logic useRt, input logic [4:0] waddr, input logic regWrite,
                       input logic memtoReg, input logic multi);
    iIssueValid = 1; iRs = rs; iUseRs = useRs; iRt = rt; iUseRt = useRt;
    iWaddr = waddr; iRegWrite = regWrite; iMemtoReg = memtoReg; iMulti = multi;
  endtask

  task automatic resetDut();
    iReset = 0;
    setIdle();
    tick();
    iReset = 1;
    #1;
  endtask

  task automatic test_reset();
    iReset = 0;
    issue(5'd3, 1, 5'd4, 1, 5'd3, 1, 1, 1);
    iBranchTaken = 1;
    #1;
    nChecks++; if ({oStallF, oStallD, oFlushD, oFlushE, oBusy} !== 5'b0) begin nFails++; $display("[TB] FAIL reset_ctrl: got %b expected 00000", {oStallF, oStallD, oFlushD, oFlushE, oBusy}); end
    nChecks++; if ({oFwdA, oFwdB} !== 4'b0) begin nFails++; $display("[TB] FAIL reset_fwd: got %b expected 0000", {oFwdA, oFwdB}); end
    nChecks++; if (oOpA !== 32'hA0A0_0001 || oOpB !== 32'hB0B0_0002) begin nFails++; $display("[TB] FAIL reset_ops: got %h %h expected a0a00001 b0b00002", oOpA, oOpB); end
  endtask

  task automatic test_alu_forward();
    resetDut();
    issue(5'd1, 1, 5'd2, 1, 5'd3, 1, 0, 0);
    #1;
    nChecks++; if (oStallF !== 1'b0) begin nFails++; $display("[TB] FAIL alu_c1_stall: got %b expected 0", oStallF); end
    tick();
    issue(5'd3, 1, 5'd5, 1, 5'd6, 1, 0, 0);
    #1;
    nChecks++; if ({oStallF, oStallD, oFlushE, oFlushD} !== 4'b1110) begin nFails++; $display("[TB] FAIL alu_c2_hazard: got %b expected 1110", {oStallF, oStallD, oFlushE, oFlushD}); end
    tick();
    nChecks++; if (oStallF !== 1'b0 || oFlushE !== 1'b0) begin nFails++; $display("[TB] FAIL alu_c3_nostall: got %b%b expected 00", oStallF, oFlushE); end
    nChecks++; if (oFwdA !== 2'b01 || oOpA !== 32'h0000_0007) begin nFails++; $display("[TB] FAIL alu_c3_fwdA: got %b %h expected 01 00000007", oFwdA, oOpA); end
    nChecks++; if (oFwdB !== 2'b00 || oOpB !== 32'hB0B0_0002) begin nFails++; $display("[TB] FAIL alu_c3_fwdB: got %b %h expected 00 b0b00002", oFwdB, oOpB); end
    tick();
    issue(5'd0, 0, 5'd3, 1, 5'd8, 1, 0, 0);
    #1;
    nChecks++; if (oFwdB !== 2'b10 || oOpB !== 32'hDEAD_BEEF || oStallF !== 1'b0) begin nFails++; $display("[TB] FAIL alu_c4_fwdW: got %b %h %b expected 10 deadbeef 0", oFwdB, oOpB, oStallF); end
  endtask

  task automatic test_priority();
    resetDut();
    issue(5'd1, 1, 5'd2, 1, 5'd7, 1, 0, 0);
    tick();
    issue(5'd1, 1, 5'd2, 1, 5'd7, 1, 0, 0);
    tick();
    setIdle();
    tick();
    issue(5'd7, 1, 5'd7, 1, 5'd9, 1, 0, 0);
    #1;
    nChecks++; if (oFwdA !== 2'b01 || oFwdB !== 2'b01 || oOpA !== 32'h0000_0007) begin nFails++; $display("[TB] FAIL prio_M_over_W: got %b %b %h expected 01 01 00000007", oFwdA, oFwdB, oOpA); end
    nChecks++; if (oStallF !== 1'b0) begin nFails++; $display("[TB] FAIL prio_stall: got %b expected 0", oStallF); end
  endtask

  task automatic test_load_use();
    resetDut();
    issue(5'd1, 1, 5'd0, 0, 5'd4, 1, 1, 0);
    tick();
    issue(5'd8, 1, 5'd4, 1, 5'd9, 1, 0, 0);
    #1;
    nChecks++; if ({oStallF, oStallD, oFlushE} !== 3'b111) begin nFails++; $display("[TB] FAIL lw_c2_stall: got %b expected 111", {oStallF, oStallD, oFlushE}); end
    tick();
    nChecks++; if ({oStallF, oStallD, oFlushE} !== 3'b111) begin nFails++; $display("[TB] FAIL lw_c3_stall: got %b expected 111", {oStallF, oStallD, oFlushE}); end
    nChecks++; if (oFwdB !== 2'b00) begin nFails++; $display("[TB] FAIL lw_c3_nofwdM: got %b expected 00", oFwdB); end
    tick();
    nChecks++; if (oStallF !== 1'b0 || oFwdB !== 2'b10 || oOpB !== 32'hDEAD_BEEF) begin nFails++; $display("[TB] FAIL lw_c4_fwdW: got %b %b %h expected 0 10 deadbeef", oStallF, oFwdB, oOpB); end
  endtask

  task automatic test_zero_reg();
    resetDut();
    issue(5'd1, 1, 5'd2, 1, 5'd0, 1, 0, 0);
    tick();
    issue(5'd0, 1, 5'd0, 1, 5'd5, 1, 0, 0);
    #1;
    nChecks++; if (oStallF !== 1'b0 || oFlushE !== 1'b0 || oFwdA !== 2'b00) begin nFails++; $display("[TB] FAIL zero_E: got %b %b %b expected 0 0 00", oStallF, oFlushE, oFwdA); end
    tick();
    nChecks++; if (oFwdA !== 2'b00 || oOpA !== 32'hA0A0_0001) begin nFails++; $display("[TB] FAIL zero_M: got %b %h expected 00 a0a00001", oFwdA, oOpA); end
  endtask

  task automatic test_use_flag();
    resetDut();
    issue(5'd1, 1, 5'd2, 1, 5'd3, 1, 0, 0);
    tick();
    issue(5'd3, 0, 5'd3, 0, 5'd6, 1, 0, 0);
    #1;
    nChecks++; if (oStallF !== 1'b0 || oFlushE !== 1'b0) begin nFails++; $display("[TB] FAIL useflag_nostall: got %b%b expected 00", oStallF, oFlushE); end
  endtask

  task automatic test_multi();
    resetDut();
    issue(5'd1, 1, 5'd2, 1, 5'd10, 1, 0, 1);
    #1;
    nChecks++; if (oBusy !== 1'b0) begin nFails++; $display("[TB] FAIL mul_c1_busy: got %b expected 0", oBusy); end
    tick();
    issue(5'd10, 1, 5'd0, 0, 5'd11, 1, 0, 0);
    #1;
    nChecks++; if ({oBusy, oStallF, oStallD, oFlushE} !== 4'b1110) begin nFails++; $display("[TB] FAIL mul_c2_busy: got %b expected 1110", {oBusy, oStallF, oStallD, oFlushE}); end
    tick();
    iBranchTaken = 1;
    #1;
    nChecks++; if ({oBusy, oStallF, oFlushD, oFlushE} !== 4'b1100) begin nFails++; $display("[TB] FAIL mul_c3_branch_ignored: got %b expected 1100", {oBusy, oStallF, oFlushD, oFlushE}); end
    tick();
    iBranchTaken = 0;
    #1;
    nChecks++; if ({oBusy, oStallF, oFlushE} !== 3'b011) begin nFails++; $display("[TB] FAIL mul_c4_hazard: got %b expected 011", {oBusy, oStallF, oFlushE}); end
    tick();
    nChecks++; if (oStallF !== 1'b0 || oFwdA !== 2'b01) begin nFails++; $display("[TB] FAIL mul_c5_fwd: got %b %b expected 0 01", oStallF, oFwdA); end
  endtask

  task automatic test_branch();
    resetDut();
    issue(5'd1, 1, 5'd0, 0, 5'd4, 1, 1, 0);
    tick();
    issue(5'd8, 1, 5'd4, 1, 5'd9, 1, 0, 0);
    iBranchTaken = 1;
    #1;
    nChecks++; if ({oFlushD, oFlushE, oStallF, oStallD} !== 4'b1100) begin nFails++; $display("[TB] FAIL branch_override: got %b expected 1100", {oFlushD, oFlushE, oStallF, oStallD}); end
  endtask

  task automatic test_reset_mid_multi();
    resetDut();
    issue(5'd1, 1, 5'd2, 1, 5'd10, 1, 0, 1);
    tick();
    setIdle();
    tick();
    iReset = 0;
    #1;
    nChecks++; if ({oBusy, oStallF, oStallD, oFlushD, oFlushE} !== 5'b0) begin nFails++; $display("[TB] FAIL rstmul_during: got %b expected 00000", {oBusy, oStallF, oStallD, oFlushD, oFlushE}); end
    tick();
    iReset = 1;
    #1;
    nChecks++; if ({oBusy, oStallF, oFlushE} !== 3'b0) begin nFails++; $display("[TB] FAIL rstmul_after: got %b expected 000", {oBusy, oStallF, oFlushE}); end
    issue(5'd10, 1, 5'd10, 1, 5'd11, 1, 0, 0);
    #1;
    nChecks++; if (oStallF !== 1'b0 || oFwdA !== 2'b00) begin nFails++; $display("[TB] FAIL rstmul_empty: got %b %b expected 0 00", oStallF, oFwdA); end
  endtask

  initial begin
    iReset = 0;
    setIdle();
    tick();
    tick();
    test_reset();
    test_alu_forward();
    test_priority();
    test_load_use();
    test_zero_reg();
    test_use_flag();
    test_multi();
    test_branch();
    test_reset_mid_multi();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
